mcntrl_chn_sched: RTL and testbench
===================================

Name: mcntrl_chn_sched

Overview:
Per-channel sequence scheduler for the memory controller.
- Arbitrates between up to 16 channel requesters and issues one sequence at a time to the shared sequencer.
- Drives the 4-bit running-channel number consumed by every per-channel buffer register stage.
- Converts the sequencer's common seq_done into a per-channel completion pulse.
- Two-level priority (urgent/normal), round-robin within each level.

Parameters:
NUM_CHN, 16, number of channels (2..16); bits above NUM_CHN-1 of all vectors are ignored.
CHN_WIDTH, 4, width of the channel number.
MIN_GAP, 1, idle cycles forced after seq_done before the next grant (0..15).

Ports:
clk  input  1  controller clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
chn_en  input  NUM_CHN  per-channel enable mask
want_rq  input  NUM_CHN  normal-priority sequence request, level
need_rq  input  NUM_CHN  urgent sequence request, level, overrides want_rq
seq_ready  input  1  sequencer can accept a new sequence
seq_done  input  1  single-cycle pulse, current sequence finished
run_start  output  1  single-cycle pulse, start sequence for run_chn
run_chn  output  CHN_WIDTH  channel being run, stable from run_start until the cycle after seq_done
run_busy  output  1  high from run_start through the seq_done cycle
grant  output  NUM_CHN  one-hot grant, same span as run_busy
chn_done  output  NUM_CHN  one-hot single-cycle completion pulse

Behaviour:
- Reset (async assert): state=IDLE; run_start=0, run_busy=0, grant=0, chn_done=0, run_chn=0, gap counter=0; rr pointer last=NUM_CHN-1, so channel 0 wins first.
- Qualified requests:
  - urg = need_rq & chn_en
  - norm = want_rq & chn_en & ~urg
  - Winner class: urg if nonzero, else norm.
  - Within the winner class, the winner is the first set bit scanning last+1, last+2, ... with modulo NUM_CHN wrap-around. The scan is combinational.
- FSM states: IDLE, START, RUN, GAP.
- IDLE:
  - If seq_ready=1 and any qualified request exists at edge n, then at n+1: state=START, run_start=1, run_chn=winner, grant=onehot(winner), run_busy=1, last=winner.
  - Otherwise stay in IDLE.
- START lasts one cycle.
  - Next state is RUN; run_start returns to 0.
  - If seq_done=1 in START, it is treated as in RUN.
- RUN: hold run_chn, grant and run_busy. On seq_done=1:
  - Next cycle: chn_done[run_chn]=1 for exactly one cycle, grant=0, run_busy=0.
  - Next state is GAP if MIN_GAP>0, else IDLE.
  - run_chn keeps its value until the next grant.
- GAP: counter loads MIN_GAP-1 on entry and decrements; state goes to IDLE after MIN_GAP cycles. Requests are not sampled in GAP.
- seq_done in IDLE or GAP: ignored, with no chn_done pulse.
- Request or enable deasserted after grant: the sequence completes normally; nothing aborts once run_start has issued.
- Simultaneous need_rq and want_rq on the same channel: counts as urgent only.
- seq_ready low in IDLE: no grant, requests keep waiting. seq_ready is not checked in other states.
- rst asserted mid-run: immediate return to reset values; no chn_done for the aborted channel.
- Back-to-back sequences with MIN_GAP=0: seq_done at n, chn_done at n+1 (state IDLE), next run_start at n+2 at the earliest.

Decomposition:
- Shared package (mcntrl_pkg) holds:
  - FSM state encoding constants
  - CHN_WIDTH default
  - the channel count constant used by the controller top
- One natural sub-module, mcntrl_rr_pick: combinational round-robin picker.
  - Inputs: rq[NUM_CHN], last[CHN_WIDTH].
  - Outputs: valid, winner[CHN_WIDTH].
  - Instantiated twice, once for urgent and once for normal, and the outputs are muxed.

Test Plan:
- Reset then want_rq=0x0001, chn_en=0xFFFF, seq_ready=1 → run_start one cycle later with run_chn=0 and grant=0x0001; seq_done 5 cycles later → chn_done=0x0001 for 1 cycle, run_busy falls.
- Round-robin: want_rq=0x0111 held, seq_done 3 cycles after each start, MIN_GAP=1 → grant order 0, 4, 8, 0, 4; gap of at least 1 idle cycle between chn_done and the next run_start.
- Priority: last=2, want_rq=0x0008, need_rq=0x0020 → run_chn=5 first, then 3.
- Masking and wrap: chn_en=0xFFF0, want_rq=0x8003 → run_chn=15; after done, no further grant while 0x0003 stays masked.
- Stray and abort: seq_done pulse in IDLE → no chn_done. want_rq dropped during RUN → sequence continues until seq_done. rst mid-RUN → grant=0 immediately, no chn_done, next grant goes to channel 0.
- seq_ready=0 with want_rq=0x0004 for 10 cycles → no run_start. Raise seq_ready → run_start next cycle with run_chn=2.

Source files
------------

// File: rtl/mcntrl_pkg.sv
// mcntrl_pkg: shared constants and FSM encoding for the memory-controller channel scheduler
package mcntrl_pkg;
  localparam int MCNTRL_NUM_CHN = 16;
  localparam int MCNTRL_CHN_WIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;
endpackage

// File: rtl/mcntrl_rr_pick.sv
// mcntrl_rr_pick: combinational round-robin picker, first request after last with wrap-around
module mcntrl_rr_pick
  import mcntrl_pkg::*;
#(
  parameter int NUM_CHN = MCNTRL_NUM_CHN,
  parameter int CHN_WIDTH = MCNTRL_CHN_WIDTH
) (
  input  logic [NUM_CHN-1:0]   rq,
  input  logic [CHN_WIDTH-1:0] last,
  output logic                 valid,
  output logic [CHN_WIDTH-1:0] winner
);
  // Scan farthest-first so the nearest request after last is the one that sticks.
  always_comb begin
    valid = 1'b0;
    winner = '0;
    for (int i = NUM_CHN; i >= 1; i--) begin
      if (rq[(int'(last) + i) % NUM_CHN]) begin
        valid = 1'b1;
        winner = CHN_WIDTH'((int'(last) + i) % NUM_CHN);
      end
    end
  end
endmodule

// File: rtl/mcntrl_chn_sched.sv
// mcntrl_chn_sched: two-level round-robin sequence scheduler driving the running-channel number
module mcntrl_chn_sched
  import mcntrl_pkg::*;
#(
  parameter int NUM_CHN = MCNTRL_NUM_CHN,
  parameter int CHN_WIDTH = MCNTRL_CHN_WIDTH,
  parameter int MIN_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CHN-1:0]   chn_en,
  input  logic [NUM_CHN-1:0]   want_rq,
  input  logic [NUM_CHN-1:0]   need_rq,
  input  logic                 seq_ready,
  input  logic                 seq_done,
  output logic                 run_start,
  output logic [CHN_WIDTH-1:0] run_chn,
  output logic                 run_busy,
  output logic [NUM_CHN-1:0]   grant,
  output logic [NUM_CHN-1:0]   chn_done
);
  localparam logic [3:0] GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;
  sched_state_e state_q, state_d;
  logic [CHN_WIDTH-1:0] run_chn_q, run_chn_d, last_q, last_d;
  logic [NUM_CHN-1:0] grant_q, grant_d, chn_done_q, chn_done_d;
  logic [3:0] gap_q, gap_d;
  logic [NUM_CHN-1:0] urg, norm;
  logic u_valid, n_valid;
  logic [CHN_WIDTH-1:0] u_win, n_win, win;
  assign urg = need_rq & chn_en;
  assign norm = want_rq & chn_en & ~urg;
  mcntrl_rr_pick #(.NUM_CHN(NUM_CHN), .CHN_WIDTH(CHN_WIDTH)) u_pick_urg (
    .rq(urg), .last(last_q), .valid(u_valid), .winner(u_win)
  );
  mcntrl_rr_pick #(.NUM_CHN(NUM_CHN), .CHN_WIDTH(CHN_WIDTH)) u_pick_norm (
    .rq(norm), .last(last_q), .valid(n_valid), .winner(n_win)
  );
  assign win = u_valid ? u_win : n_win;
  always_comb begin
    state_d = state_q;
    run_chn_d = run_chn_q;
    last_d = last_q;
    grant_d = grant_q;
    gap_d = gap_q;
    chn_done_d = '0;
    case (state_q)
      ST_IDLE: if (seq_ready && (u_valid || n_valid)) begin
        state_d = ST_START;
        run_chn_d = win;
        last_d = win;
        grant_d = NUM_CHN'(1) << win;
      end
      ST_START, ST_RUN: begin
        state_d = ST_RUN;
        if (seq_done) begin
          state_d = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
          chn_done_d = grant_q;
          grant_d = '0;
          gap_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        gap_d = (gap_q == 4'd0) ? 4'd0 : gap_q - 4'd1;
        state_d = (gap_q == 4'd0) ? ST_IDLE : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_chn_q <= '0;
      last_q <= CHN_WIDTH'(NUM_CHN - 1);
      grant_q <= '0;
      gap_q <= '0;
      chn_done_q <= '0;
    end else begin
      state_q <= state_d;
      run_chn_q <= run_chn_d;
      last_q <= last_d;
      grant_q <= grant_d;
      gap_q <= gap_d;
      chn_done_q <= chn_done_d;
    end
  end
  assign run_start = (state_q == ST_START);
  assign run_busy = (state_q == ST_START) || (state_q == ST_RUN);
  assign run_chn = run_chn_q;
  assign grant = grant_q;
  assign chn_done = chn_done_q;
endmodule

// File: tb/tb_mcntrl_chn_sched.sv
// tb_mcntrl_chn_sched: directed checks of arbitration, priority, masking, gaps and abort
module tb_mcntrl_chn_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] chn_en = '0, want_rq = '0, need_rq = '0;
  logic seq_ready = 1'b0, seq_done = 1'b0;
  logic run_start, run_busy;
  logic [3:0] run_chn;
  logic [15:0] grant, chn_done;
  int checks = 0, failures = 0;

  mcntrl_chn_sched dut (
    .clk(clk), .rst(rst), .chn_en(chn_en), .want_rq(want_rq), .need_rq(need_rq),
    .seq_ready(seq_ready), .seq_done(seq_done), .run_start(run_start), .run_chn(run_chn),
    .run_busy(run_busy), .grant(grant), .chn_done(chn_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_start", {31'd0, run_start}, 0);
    chk("rst_busy", {31'd0, run_busy}, 0);
    chk("rst_grant", {16'd0, grant}, 0);
    chk("rst_done", {16'd0, chn_done}, 0);
    chk("rst_chn", {28'd0, run_chn}, 0);
    rst = 1'b0;
  endtask

  // Waits for a start, checks the grant, holds the sequence, then checks the completion pulse.
  task automatic do_seq(input string tag, input int exp_chn, input int hold, input logic [15:0] drop);
    int n = 0;
    while (!run_start && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_start"}, {31'd0, run_start}, 1);
    chk({tag, "_chn"}, {28'd0, run_chn}, exp_chn);
    chk({tag, "_grant"}, {16'd0, grant}, 32'd1 << exp_chn);
    chk({tag, "_busy"}, {31'd0, run_busy}, 1);
    want_rq &= ~drop;
    need_rq &= ~drop;
    repeat (hold - 1) step();
    chk({tag, "_hold"}, {16'd0, grant}, 32'd1 << exp_chn);
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    chk({tag, "_cdone"}, {16'd0, chn_done}, 32'd1 << exp_chn);
    chk({tag, "_idle"}, {31'd0, run_busy}, 0);
    chk({tag, "_gnt0"}, {16'd0, grant}, 0);
    chk({tag, "_keep"}, {28'd0, run_chn}, exp_chn);
    step();
    chk({tag, "_pulse"}, {16'd0, chn_done}, 0);
    chk({tag, "_gap"}, {31'd0, run_start}, 0);
  endtask

  initial begin
    int seen;
    do_reset();
    // Basic single request with exact one-cycle latency.
    chn_en = 16'hFFFF;
    seq_ready = 1'b1;
    want_rq = 16'h0001;
    step();
    chk("t1_lat", {31'd0, run_start}, 1);
    do_seq("t1", 0, 5, 16'h0001);
    // Round-robin among 0, 4, 8 from a fresh pointer.
    do_reset();
    want_rq = 16'h0111;
    do_seq("rr0", 0, 3, 16'h0000);
    do_seq("rr1", 4, 3, 16'h0000);
    do_seq("rr2", 8, 3, 16'h0000);
    do_seq("rr3", 0, 3, 16'h0000);
    do_seq("rr4", 4, 3, 16'h0111);
    // Urgent beats normal: last=2, need on 5, want on 3.
    do_reset();
    want_rq = 16'h0004;
    do_seq("p0", 2, 2, 16'h0004);
    want_rq = 16'h0008;
    need_rq = 16'h0020;
    do_seq("p1", 5, 2, 16'h0020);
    do_seq("p2", 3, 2, 16'h0008);
    // Masked channels never win; re-enabling them wraps to channel 0.
    chn_en = 16'hFFF0;
    want_rq = 16'h8003;
    do_seq("m0", 15, 3, 16'h8000);
    seen = 0;
    repeat (10) begin
      step();
      seen |= int'(run_start);
    end
    chk("m_nogrant", seen, 0);
    chn_en = 16'hFFFF;
    do_seq("m1", 0, 2, 16'h0003);
    // Stray seq_done in IDLE produces nothing.
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    chk("stray_done", {16'd0, chn_done}, 0);
    step();
    chk("stray_done2", {16'd0, chn_done}, 0);
    // Request withdrawn right after start still completes.
    want_rq = 16'h0010;
    do_seq("d0", 4, 4, 16'h0010);
    // Asynchronous reset mid-run.
    want_rq = 16'h0040;
    step();
    chk("a0_start", {31'd0, run_start}, 1);
    chk("a0_chn", {28'd0, run_chn}, 6);
    step();
    #2 rst = 1'b1;
    #1;
    chk("a_grant", {16'd0, grant}, 0);
    chk("a_busy", {31'd0, run_busy}, 0);
    chk("a_chn", {28'd0, run_chn}, 0);
    want_rq = 16'h0041;
    step();
    chk("a_nodone", {16'd0, chn_done}, 0);
    rst = 1'b0;
    do_seq("a1", 0, 2, 16'h0001);
    do_seq("a2", 6, 2, 16'h0040);
    // seq_ready low holds off the grant.
    seq_ready = 1'b0;
    want_rq = 16'h0004;
    seen = 0;
    repeat (10) begin
      step();
      seen |= int'(run_start);
    end
    chk("r_nostart", seen, 0);
    seq_ready = 1'b1;
    step();
    chk("r_start", {31'd0, run_start}, 1);
    do_seq("r0", 2, 2, 16'h0004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
